car_controller: RTL
===================

Name: car_controller

Overview:
- Motion/door sequencer for the 2-way, 7-floor car; consumes the latched hall-call and car-call vectors from the button-latch stage.
- Produces currentFloor, currentDirection, doorState and move, which feed back into the button-latch stage so it clears served calls.
- Runs a 4-state FSM with floor-travel and door-dwell counters; advances only on enable ticks.

Parameters:
- NUM_FLOORS, 7: served floors, numbered 1..NUM_FLOORS.
- TRAVEL_TICKS, 4: enable ticks to travel one floor; must be >=1.
- DOOR_TICKS, 3: enable ticks the door stays open; must be >=2 so the button stage clears calls before close.
- CNT_W, 4: counter width; must satisfy 2^CNT_W > max(TRAVEL_TICKS, DOOR_TICKS).

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- enable  in  1  tick qualifier; no state, counter or output changes when 0
- floorButton  in  14  hall calls; bit 2*(f-1) = up call at floor f, bit 2*(f-1)+1 = down call
- internalButton  in  9 [9:1]  car calls; bits 8..9 ignored
- currentFloor  out  3  floor 1..7
- currentDirection  out  2  [0]=up, [1]=down; 00 none; 11 only on an idle open with both hall calls
- doorState  out  1  1=OPEN, 0=CLOSE
- move  out  1  1=MOVE, 0=HOLD

Behaviour:
- reset (priority over enable): currentFloor=1, currentDirection=00, doorState=0, move=0, state=IDLE, both counters=0. Reset mid-travel returns the car to floor 1 with no intermediate floor.
- req[f] = internalButton[f] | up call at f | down call at f. above = any req[f] with f>currentFloor. below = any req[f] with f<currentFloor.
- All transitions below occur on clk edges with enable=1. Outputs are registered and change in the same edge as the state change.
- IDLE (dir 00, door 0, move 0):
  - if req[currentFloor]: go to OPEN; door=1; dir={down call here, up call here}; dir=00 if only the car call is set.
  - else if above: go to MOVING; dir=01; move=1.
  - else if below: go to MOVING; dir=10; move=1. Up wins when both above and below are set.
  - else stay in IDLE.
- MOVING (move=1):
  - travel counter increments each tick. At TRAVEL_TICKS-1: counter clears; floor moves +1 (dir 01) or -1 (dir 10).
  - Then evaluate the new floor f:
    - stop if internalButton[f], or a hall call in the current direction at f, or no request beyond f in the current direction.
    - on stop: move=0, door=1, go to OPEN.
    - if stopping with nothing beyond: dir becomes the opposite hall-call direction if that call is present at f, else it is kept.
  - Floor never leaves 1..7; at floor 7 (or 1) nothing lies beyond, so the car stops.
- OPEN (door=1, move=0):
  - dwell counter increments each tick.
  - At DOOR_TICKS-1: counter clears; door=0; go to CLOSING.
  - Dwell is not restarted by new calls.
- CLOSING (one tick, door=0, move=0; lets the button stage clear the car call via HOLD). Decision in this tick, checked in order:
  - requests beyond in dir: MOVING, same dir.
  - requests in the opposite direction: MOVING, opposite dir.
  - hall call at currentFloor: OPEN, dir = that call's direction.
  - otherwise: IDLE, dir=00.
  - If dir was 00 entering CLOSING, apply the IDLE rules instead.
- Invariant: door=1 and move=1 never occur together.
- Requests that change during MOVING are sampled only at floor arrival.

Decomposition:
- elevator_pkg holds:
  - NUM_FLOORS.
  - Constants DIR_NONE=2'b00, DIR_UP=2'b01, DIR_DOWN=2'b10, OPEN/CLOSE, MOVE/HOLD.
  - FSM state encoding: IDLE, OPEN, CLOSING, MOVING.
  - Floor/button index helper functions.
- One sub-module, request_scan: combinational. Takes the req vector, currentFloor and dir; returns above, below, here, beyond and opposite flags.

Test Plan:
- Reset then hold 5 ticks with no calls -> floor=1, dir=00, door=0, move=0 throughout.
- Idle at 1, internalButton[3]=1 (bench clears it when door=1 at floor 3):
  - next tick: MOVING, dir=01, move=1.
  - after 4 more ticks: floor=2; after 8: floor=3, door=1, move=0.
  - 3 ticks later: CLOSING; next tick: IDLE, dir=00.
- Idle at 1, up call at 1 (bit0) -> next tick: door=1, dir=01, move=0, floor unchanged.
- From 1, internalButton[5] plus down call at 3 (bit5):
  - car passes 3 without stopping, stops at 5.
  - then MOVING, dir=10; stops at 3 with dir=10, door=1.
- Only a down call at 7 (bit13), car at 1 -> travels to 7, stops with dir=10, door=1; floor never exceeds 7.
- enable=0 for 10 cycles mid-travel -> no output or counter change.
- Assert reset at floor 4 while moving -> next edge floor=1, move=0, door=0.

Source files
------------

// File: rtl/elevator_pkg.sv
// Shared definitions for the car motion/door sequencer: floor count,
// direction/door/motion encodings, FSM states and hall-call bit helpers.
package elevator_pkg;

  localparam int NUM_FLOORS = 7;
  localparam int FLOOR_W    = 3;

  localparam logic [1:0] DIR_NONE = 2'b00;
  localparam logic [1:0] DIR_UP   = 2'b01;
  localparam logic [1:0] DIR_DOWN = 2'b10;

  localparam logic DOOR_OPEN  = 1'b1;
  localparam logic DOOR_CLOSE = 1'b0;
  localparam logic MOVE       = 1'b1;
  localparam logic HOLD       = 1'b0;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    OPEN    = 2'd1,
    CLOSING = 2'd2,
    MOVING  = 2'd3
  } state_e;

  // Hall-call vector bit positions for floor f (1-based).
  function automatic int up_bit(input int f);
    return 2 * (f - 1);
  endfunction

  function automatic int dn_bit(input int f);
    return 2 * (f - 1) + 1;
  endfunction

  // Per-floor flag lookup; floors outside 1..NUM_FLOORS read as 0.
  function automatic logic bit_at(input logic [NUM_FLOORS:1] v,
                                  input logic [FLOOR_W-1:0] fl);
    logic r;
    r = 1'b0;
    for (int f = 1; f <= NUM_FLOORS; f++) begin
      if (fl == FLOOR_W'(f)) r = v[f];
    end
    return r;
  endfunction

endpackage

// File: rtl/car_controller_request_scan.sv
// request_scan: combinational classification of pending requests relative
// to a floor and a travel direction.
//   req_i      per-floor request vector (car or hall call), floors 1..N
//   floor_i    reference floor
//   dir_i      travel direction (DIR_UP / DIR_DOWN / other)
//   above_o    any request strictly above floor_i
//   below_o    any request strictly below floor_i
//   here_o     request at floor_i
//   beyond_o   any request further along dir_i (0 when dir is not up/down)
//   opposite_o any request against dir_i (0 when dir is not up/down)
module request_scan
  import elevator_pkg::*;
(
  input  logic [NUM_FLOORS:1] req_i,
  input  logic [FLOOR_W-1:0]  floor_i,
  input  logic [1:0]          dir_i,
  output logic                above_o,
  output logic                below_o,
  output logic                here_o,
  output logic                beyond_o,
  output logic                opposite_o
);

  always_comb begin
    above_o    = 1'b0;
    below_o    = 1'b0;
    here_o     = 1'b0;
    beyond_o   = 1'b0;
    opposite_o = 1'b0;
    for (int f = 1; f <= NUM_FLOORS; f++) begin
      if (FLOOR_W'(f) > floor_i)      above_o = above_o | req_i[f];
      else if (FLOOR_W'(f) < floor_i) below_o = below_o | req_i[f];
      else                            here_o  = req_i[f];
    end
    case (dir_i)
      DIR_UP:   begin beyond_o = above_o; opposite_o = below_o; end
      DIR_DOWN: begin beyond_o = below_o; opposite_o = above_o; end
      default:  ;
    endcase
  end

endmodule

// File: rtl/car_controller.sv
// car_controller: motion/door sequencer for a 2-way car serving floors
// 1..NUM_FLOORS. Advances only on enable ticks.
//   clk, reset        clock, synchronous active-high reset
//   enable            tick qualifier; nothing changes while low
//   floorButton       latched hall calls, even bit = up, odd bit = down
//   internalButton    latched car calls [9:1]; bits above NUM_FLOORS unused
//   currentFloor      floor 1..NUM_FLOORS
//   currentDirection  [0]=up, [1]=down
//   doorState         1=open, 0=closed
//   move              1=moving, 0=holding
module car_controller
  import elevator_pkg::*;
#(
  parameter int TRAVEL_TICKS = 4,
  parameter int DOOR_TICKS   = 3,
  parameter int CNT_W        = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    enable,
  input  logic [2*NUM_FLOORS-1:0] floorButton,
  input  logic [9:1]              internalButton,
  output logic [FLOOR_W-1:0]      currentFloor,
  output logic [1:0]              currentDirection,
  output logic                    doorState,
  output logic                    move
);

  localparam logic [CNT_W-1:0] TRAVEL_LAST = CNT_W'(TRAVEL_TICKS - 1);
  localparam logic [CNT_W-1:0] DOOR_LAST   = CNT_W'(DOOR_TICKS - 1);

  state_e               state_q, state_d;
  logic [FLOOR_W-1:0]   floor_q, floor_d;
  logic [1:0]           dir_q, dir_d;
  logic                 door_q, door_d;
  logic                 move_q, move_d;
  logic [CNT_W-1:0]     travel_q, travel_d;
  logic [CNT_W-1:0]     dwell_q, dwell_d;

  logic [NUM_FLOORS:1]  up_at, dn_at, car_at, req;
  logic [FLOOR_W-1:0]   arr_floor;
  logic                 above, below, here, beyond, opposite;
  logic                 arr_above, arr_below, arr_here, arr_beyond, arr_opposite;
  logic                 up_here, dn_here, stop;
  logic                 unused_car_bits;

  assign unused_car_bits = ^internalButton[9:NUM_FLOORS+1];

  always_comb begin
    for (int f = 1; f <= NUM_FLOORS; f++) begin
      up_at[f]  = floorButton[up_bit(f)];
      dn_at[f]  = floorButton[dn_bit(f)];
      car_at[f] = internalButton[f];
      req[f]    = car_at[f] | up_at[f] | dn_at[f];
    end
  end

  // Floor the car reaches at the end of the current travel leg; clamped so
  // it can never leave 1..NUM_FLOORS.
  always_comb begin
    arr_floor = floor_q;
    if (dir_q == DIR_UP && floor_q < FLOOR_W'(NUM_FLOORS))
      arr_floor = floor_q + FLOOR_W'(1);
    else if (dir_q == DIR_DOWN && floor_q > FLOOR_W'(1))
      arr_floor = floor_q - FLOOR_W'(1);
  end

  request_scan u_scan_cur (
    .req_i(req), .floor_i(floor_q), .dir_i(dir_q),
    .above_o(above), .below_o(below), .here_o(here),
    .beyond_o(beyond), .opposite_o(opposite)
  );

  request_scan u_scan_arr (
    .req_i(req), .floor_i(arr_floor), .dir_i(dir_q),
    .above_o(arr_above), .below_o(arr_below), .here_o(arr_here),
    .beyond_o(arr_beyond), .opposite_o(arr_opposite)
  );

  assign up_here = bit_at(up_at, floor_q);
  assign dn_here = bit_at(dn_at, floor_q);

  // Stop at the arrival floor for a car call, a hall call in our direction,
  // or when nothing further lies ahead (which also covers the end floors).
  assign stop = bit_at(car_at, arr_floor)
              | ((dir_q == DIR_UP)   & bit_at(up_at, arr_floor))
              | ((dir_q == DIR_DOWN) & bit_at(dn_at, arr_floor))
              | ~arr_beyond;

  always_comb begin
    state_d  = state_q;
    floor_d  = floor_q;
    dir_d    = dir_q;
    door_d   = door_q;
    move_d   = move_q;
    travel_d = travel_q;
    dwell_d  = dwell_q;
    if (enable) begin
      // A CLOSING car with no direction behaves exactly like an idle car.
      if (state_q == IDLE || (state_q == CLOSING && dir_q == DIR_NONE)) begin
        state_d = IDLE;
        dir_d   = DIR_NONE;
        door_d  = DOOR_CLOSE;
        move_d  = HOLD;
        if (here) begin
          state_d = OPEN;
          door_d  = DOOR_OPEN;
          dir_d   = {dn_here, up_here};
          dwell_d = '0;
        end else if (above) begin
          state_d  = MOVING;
          dir_d    = DIR_UP;
          move_d   = MOVE;
          travel_d = '0;
        end else if (below) begin
          state_d  = MOVING;
          dir_d    = DIR_DOWN;
          move_d   = MOVE;
          travel_d = '0;
        end
      end else begin
        case (state_q)
          MOVING: begin
            if (travel_q == TRAVEL_LAST) begin
              travel_d = '0;
              floor_d  = arr_floor;
              if (stop) begin
                state_d = OPEN;
                door_d  = DOOR_OPEN;
                move_d  = HOLD;
                dwell_d = '0;
                // Turning around at the last request: pick up the opposite
                // hall call here if there is one.
                if (!arr_beyond) begin
                  if (dir_q == DIR_UP && bit_at(dn_at, arr_floor))
                    dir_d = DIR_DOWN;
                  else if (dir_q == DIR_DOWN && bit_at(up_at, arr_floor))
                    dir_d = DIR_UP;
                end
              end
            end else begin
              travel_d = travel_q + CNT_W'(1);
            end
          end
          OPEN: begin
            if (dwell_q == DOOR_LAST) begin
              dwell_d = '0;
              door_d  = DOOR_CLOSE;
              state_d = CLOSING;
            end else begin
              dwell_d = dwell_q + CNT_W'(1);
            end
          end
          CLOSING: begin
            door_d = DOOR_CLOSE;
            move_d = HOLD;
            if (beyond) begin
              state_d  = MOVING;
              move_d   = MOVE;
              travel_d = '0;
            end else if (opposite) begin
              state_d  = MOVING;
              move_d   = MOVE;
              dir_d    = {dir_q[0], dir_q[1]};
              travel_d = '0;
            end else if (up_here | dn_here) begin
              state_d = OPEN;
              door_d  = DOOR_OPEN;
              dir_d   = {dn_here, up_here};
              dwell_d = '0;
            end else begin
              state_d = IDLE;
              dir_d   = DIR_NONE;
            end
          end
          default: state_d = IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      floor_q  <= FLOOR_W'(1);
      dir_q    <= DIR_NONE;
      door_q   <= DOOR_CLOSE;
      move_q   <= HOLD;
      travel_q <= '0;
      dwell_q  <= '0;
    end else begin
      state_q  <= state_d;
      floor_q  <= floor_d;
      dir_q    <= dir_d;
      door_q   <= door_d;
      move_q   <= move_d;
      travel_q <= travel_d;
      dwell_q  <= dwell_d;
    end
  end

  assign currentFloor     = floor_q;
  assign currentDirection = dir_q;
  assign doorState        = door_q;
  assign move             = move_q;

endmodule
